// File: rtl/llsc_ctrl_pkg.sv
// Shared definitions for the LL/SC controller: op encodings, FSM states and
// the width of the word-granular link address.
package llsc_ctrl_pkg;

  localparam int LINK_AW = 30;

  typedef enum logic [1:0] {
    LLSC_NONE = 2'b00,
    LLSC_LL   = 2'b01,
    LLSC_SC   = 2'b10
  } llsc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LL_RD = 2'b01,
    ST_SC_WR = 2'b10,
    ST_DONE  = 2'b11
  } llsc_state_e;

endpackage

// File: rtl/llsc_ctrl_if.sv
// Memory bus seen by the LL/SC controller: a single outstanding request held
// stable until the slave acknowledges it.
interface llsc_ctrl_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/llsc_ctrl.sv
// Load-linked / store-conditional controller for the MEM stage. Tracks the
// linked word, drives the external link bit and performs the bus accesses.
module llsc_ctrl
  import llsc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [31:0]       op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall_o,
  output logic [31:0]       result_o,
  output logic              result_valid_o,
  output logic              align_err_o,
  llsc_ctrl_if.master       bus,
  input  logic              snoop_we_i,
  input  logic [31:0]       snoop_addr_i,
  input  logic              llbit_i,
  output logic              llbit_we_o,
  output logic              llbit_wdata_o
);

  llsc_state_e        state_q, state_d;
  logic [LINK_AW-1:0] link_q, link_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               align_err_q, align_err_d;
  logic               sc_flush_q, sc_flush_d;

  logic snoop_hit, is_ll, is_sc, misaligned, sc_pass, sc_abandon;

  // Shift keeps every snoop address bit in the compare; bits [1:0] fall out.
  assign snoop_hit  = snoop_we_i && llbit_i && ((snoop_addr_i >> 2) == {2'b00, link_q});
  assign is_ll      = (op == LLSC_LL);
  assign is_sc      = (op == LLSC_SC);
  assign misaligned = (op_addr[1:0] != 2'b00);
  assign sc_pass    = llbit_i && (link_q == op_addr[31:2]) && !snoop_hit;
  assign sc_abandon = flush || sc_flush_q;

  always_comb begin
    state_d       = state_q;
    link_d        = link_q;
    result_d      = result_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    align_err_d   = 1'b0;
    sc_flush_d    = sc_flush_q;
    stall_o       = 1'b0;
    llbit_we_o    = 1'b0;
    llbit_wdata_o = 1'b0;

    if (snoop_hit) begin
      llbit_we_o    = 1'b1;
      llbit_wdata_o = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!flush && op_valid && (is_ll || is_sc)) begin
          if (misaligned) begin
            align_err_d = 1'b1;
          end else begin
            stall_o    = 1'b1;
            addr_d     = op_addr;
            wdata_d    = op_wdata;
            sc_flush_d = 1'b0;
            if (is_ll) begin
              state_d = ST_LL_RD;
            end else if (sc_pass) begin
              state_d = ST_SC_WR;
            end else begin
              result_d      = 32'd0;
              llbit_we_o    = 1'b1;
              llbit_wdata_o = 1'b0;
              state_d       = ST_DONE;
            end
          end
        end
      end
      ST_LL_RD: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          if (bus.bus_ack_i) begin
            result_d      = bus.bus_rdata_i;
            link_d        = addr_q[31:2];
            llbit_we_o    = 1'b1;
            llbit_wdata_o = 1'b1;
            state_d       = ST_DONE;
          end
        end
      end
      ST_SC_WR: begin
        // A flushed SC still finishes its write but reports nothing.
        stall_o = !sc_abandon;
        if (flush) sc_flush_d = 1'b1;
        if (bus.bus_ack_i) begin
          result_d      = 32'd1;
          llbit_we_o    = 1'b1;
          llbit_wdata_o = 1'b0;
          state_d       = sc_abandon ? ST_IDLE : ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush && (state_q != ST_SC_WR)) begin
      llbit_we_o    = 1'b0;
      llbit_wdata_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      link_q      <= '0;
      result_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      align_err_q <= 1'b0;
      sc_flush_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      link_q      <= link_d;
      result_q    <= result_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      align_err_q <= align_err_d;
      sc_flush_q  <= sc_flush_d;
    end
  end

  assign result_o        = result_q;
  assign result_valid_o  = (state_q == ST_DONE) && !flush;
  assign align_err_o     = align_err_q;
  assign bus.bus_req_o   = (state_q == ST_LL_RD) || (state_q == ST_SC_WR);
  assign bus.bus_we_o    = (state_q == ST_SC_WR);
  assign bus.bus_addr_o  = addr_q;
  assign bus.bus_wdata_o = wdata_q;

endmodule
